// File: rtl/ethernet_rx.sv
// ethernet_rx: receive path for Ethernet/IPv4/UDP frames carrying a 4-byte
// application header. Strips preamble/SFD, filters and parses headers,
// forwards payload bytes, checks the CRC-32 FCS and reports per-frame status.
`timescale 1ns/1ps

module ethernet_rx #(
  parameter logic [47:0] MAC_ADDR    = 48'h00_0A_35_00_00_01,
  parameter logic [15:0] UDP_PORT    = 16'd4660,
  parameter logic [14:0] MAX_PAYLOAD = 15'd1458
) (
  input  logic        i_clk_125,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_data_valid,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic        o_hdr_valid,
  output logic [7:0]  o_row_number,
  output logic [15:0] o_segment_num,
  output logic        o_sof,
  output logic        o_param_flag,
  output logic [14:0] o_data_byte,
  output logic        o_frame_done,
  output logic        o_frame_ok,
  output logic        o_crc_err,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_HEADER   = 3'd2,
    S_PAYLOAD  = 3'd3,
    S_TRAILER  = 3'd4,
    S_DROP     = 3'd5
  } state_t;

  localparam logic [7:0]  BYTE_PRE    = 8'h55;
  localparam logic [7:0]  BYTE_SFD    = 8'hD5;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;

  // Reflected CRC-32 update for one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // Destination MAC byte expected at header offset idx (0 = most significant).
  function automatic logic [7:0] mac_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return MAC_ADDR[47:40];
      3'd1:    return MAC_ADDR[39:32];
      3'd2:    return MAC_ADDR[31:24];
      3'd3:    return MAC_ADDR[23:16];
      3'd4:    return MAC_ADDR[15:8];
      3'd5:    return MAC_ADDR[7:0];
      default: return 8'h00;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [5:0]  hdr_cnt_q, hdr_cnt_d;
  logic [14:0] pay_cnt_q, pay_cnt_d;
  logic [2:0]  trl_cnt_q, trl_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        mac_ok_q, mac_ok_d;
  logic        bc_ok_q, bc_ok_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [14:0] pay_len_q, pay_len_d;
  logic [7:0]  row_cap_q, row_cap_d;
  logic [7:0]  seg_hi_q, seg_hi_d;
  logic [7:0]  seg_lo_q, seg_lo_d;

  logic [7:0]  data_q, data_d;
  logic        data_valid_q, data_valid_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic [7:0]  row_q, row_d;
  logic [15:0] seg_q, seg_d;
  logic        sof_q, sof_d;
  logic        param_q, param_d;
  logic [14:0] data_byte_q, data_byte_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic [15:0] len_s;
  logic        mac_ok_nxt_s;
  logic        bc_ok_nxt_s;
  logic        crc_good_s;
  logic        hdr_fail_s;

  assign len_s        = {len_hi_q, i_data};
  assign mac_ok_nxt_s = mac_ok_q & (i_data == mac_byte(hdr_cnt_q[2:0]));
  assign bc_ok_nxt_s  = bc_ok_q & (i_data == 8'hFF);
  assign crc_good_s   = (crc_q == CRC_RESIDUE);

  // Header filter: flags a mismatch on the byte currently at hdr_cnt_q.
  always_comb begin
    hdr_fail_s = 1'b0;
    case (hdr_cnt_q)
      6'd0, 6'd1, 6'd2,
      6'd3, 6'd4, 6'd5: hdr_fail_s = !(mac_ok_nxt_s || bc_ok_nxt_s);
      6'd12:            hdr_fail_s = (i_data != 8'h08);
      6'd13:            hdr_fail_s = (i_data != 8'h00);
      6'd14:            hdr_fail_s = (i_data != 8'h45);
      6'd23:            hdr_fail_s = (i_data != 8'h11);
      6'd36:            hdr_fail_s = (i_data != UDP_PORT[15:8]);
      6'd37:            hdr_fail_s = (i_data != UDP_PORT[7:0]);
      6'd39:            hdr_fail_s = (len_s < 16'd12) || (len_s > ({1'b0, MAX_PAYLOAD} + 16'd12));
      default:          hdr_fail_s = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk_125 or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!i_data_valid)            state_d = S_IDLE;
        else if (i_data == BYTE_PRE)  state_d = S_PREAMBLE;
        else if (i_data == BYTE_SFD)  state_d = S_HEADER;
        else                          state_d = S_DROP;
      end
      S_PREAMBLE: begin
        if (!i_data_valid)                                  state_d = S_IDLE;
        else if (i_data == BYTE_SFD)                        state_d = S_HEADER;
        else if (i_data == BYTE_PRE && pre_cnt_q != 3'd7)   state_d = S_PREAMBLE;
        else                                                state_d = S_DROP;
      end
      S_HEADER: begin
        if (!i_data_valid)             state_d = S_IDLE;
        else if (hdr_fail_s)           state_d = S_DROP;
        else if (hdr_cnt_q == 6'd45)   state_d = (pay_len_q == 15'd0) ? S_TRAILER : S_PAYLOAD;
        else                           state_d = S_HEADER;
      end
      S_PAYLOAD: begin
        if (!i_data_valid)                         state_d = S_IDLE;
        else if (pay_cnt_q == pay_len_q - 15'd1)   state_d = S_TRAILER;
        else                                       state_d = S_PAYLOAD;
      end
      S_TRAILER: begin
        if (!i_data_valid) state_d = S_IDLE;
        else               state_d = S_TRAILER;
      end
      S_DROP: begin
        if (!i_data_valid) state_d = S_IDLE;
        else               state_d = S_DROP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: counters, CRC accumulator and header captures.
  always_comb begin
    pre_cnt_d = 3'd0;
    hdr_cnt_d = 6'd0;
    pay_cnt_d = 15'd0;
    trl_cnt_d = 3'd0;
    crc_d     = crc_q;
    mac_ok_d  = 1'b1;
    bc_ok_d   = 1'b1;
    len_hi_d  = len_hi_q;
    pay_len_d = pay_len_q;
    row_cap_d = row_cap_q;
    seg_hi_d  = seg_hi_q;
    seg_lo_d  = seg_lo_q;
    case (state_q)
      S_IDLE, S_PREAMBLE: begin
        crc_d = CRC_INIT;
        if (i_data_valid && i_data == BYTE_PRE) begin
          pre_cnt_d = (state_q == S_IDLE) ? 3'd1 : pre_cnt_q + 3'd1;
        end else begin
          pre_cnt_d = 3'd0;
        end
      end
      S_HEADER: begin
        if (i_data_valid) begin
          crc_d     = crc32_byte(crc_q, i_data);
          hdr_cnt_d = hdr_cnt_q + 6'd1;
          if (hdr_cnt_q < 6'd6) begin
            mac_ok_d = mac_ok_nxt_s;
            bc_ok_d  = bc_ok_nxt_s;
          end else begin
            mac_ok_d = mac_ok_q;
            bc_ok_d  = bc_ok_q;
          end
          if (hdr_cnt_q == 6'd38) len_hi_d  = i_data;
          else                    len_hi_d  = len_hi_q;
          if (hdr_cnt_q == 6'd39) pay_len_d = len_s[14:0] - 15'd12;
          else                    pay_len_d = pay_len_q;
          if (hdr_cnt_q == 6'd42) row_cap_d = i_data;
          else                    row_cap_d = row_cap_q;
          if (hdr_cnt_q == 6'd43) seg_hi_d  = i_data;
          else                    seg_hi_d  = seg_hi_q;
          if (hdr_cnt_q == 6'd44) seg_lo_d  = i_data;
          else                    seg_lo_d  = seg_lo_q;
        end else begin
          hdr_cnt_d = 6'd0;
        end
      end
      S_PAYLOAD: begin
        if (i_data_valid) begin
          crc_d     = crc32_byte(crc_q, i_data);
          pay_cnt_d = pay_cnt_q + 15'd1;
        end else begin
          pay_cnt_d = 15'd0;
        end
      end
      S_TRAILER: begin
        if (i_data_valid) begin
          crc_d     = crc32_byte(crc_q, i_data);
          trl_cnt_d = (trl_cnt_q == 3'd4) ? trl_cnt_q : trl_cnt_q + 3'd1;
        end else begin
          trl_cnt_d = trl_cnt_q;
        end
      end
      default: crc_d = CRC_INIT;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge i_clk_125 or posedge i_rst) begin
    if (i_rst) begin
      pre_cnt_q <= 3'd0;
      hdr_cnt_q <= 6'd0;
      pay_cnt_q <= 15'd0;
      trl_cnt_q <= 3'd0;
      crc_q     <= CRC_INIT;
      mac_ok_q  <= 1'b1;
      bc_ok_q   <= 1'b1;
      len_hi_q  <= 8'd0;
      pay_len_q <= 15'd0;
      row_cap_q <= 8'd0;
      seg_hi_q  <= 8'd0;
      seg_lo_q  <= 8'd0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      hdr_cnt_q <= hdr_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      trl_cnt_q <= trl_cnt_d;
      crc_q     <= crc_d;
      mac_ok_q  <= mac_ok_d;
      bc_ok_q   <= bc_ok_d;
      len_hi_q  <= len_hi_d;
      pay_len_q <= pay_len_d;
      row_cap_q <= row_cap_d;
      seg_hi_q  <= seg_hi_d;
      seg_lo_q  <= seg_lo_d;
    end
  end

  // FSM output logic: next values of the registered outputs.
  always_comb begin
    data_d       = data_q;
    data_valid_d = 1'b0;
    hdr_valid_d  = 1'b0;
    row_d        = row_q;
    seg_d        = seg_q;
    sof_d        = sof_q;
    param_d      = param_q;
    data_byte_d  = data_byte_q;
    done_d       = 1'b0;
    ok_d         = 1'b0;
    err_d        = 1'b0;
    busy_d       = (state_d != S_IDLE);
    case (state_q)
      S_HEADER: begin
        if (!i_data_valid) begin
          done_d = 1'b1;
          err_d  = !crc_good_s;
        end else if (hdr_cnt_q == 6'd45 && !hdr_fail_s) begin
          hdr_valid_d = 1'b1;
          row_d       = row_cap_q;
          seg_d       = {seg_hi_q, seg_lo_q};
          sof_d       = i_data[3];
          param_d     = i_data[4];
          data_byte_d = pay_len_q;
        end else begin
          hdr_valid_d = 1'b0;
        end
      end
      S_PAYLOAD: begin
        if (i_data_valid) begin
          data_d       = i_data;
          data_valid_d = 1'b1;
        end else begin
          done_d = 1'b1;
          err_d  = !crc_good_s;
        end
      end
      S_TRAILER: begin
        if (!i_data_valid) begin
          done_d = 1'b1;
          ok_d   = (trl_cnt_q == 3'd4) && crc_good_s;
          err_d  = !crc_good_s;
        end else begin
          done_d = 1'b0;
        end
      end
      default: done_d = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge i_clk_125 or posedge i_rst) begin
    if (i_rst) begin
      data_q       <= 8'd0;
      data_valid_q <= 1'b0;
      hdr_valid_q  <= 1'b0;
      row_q        <= 8'd0;
      seg_q        <= 16'd0;
      sof_q        <= 1'b0;
      param_q      <= 1'b0;
      data_byte_q  <= 15'd0;
      done_q       <= 1'b0;
      ok_q         <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      hdr_valid_q  <= hdr_valid_d;
      row_q        <= row_d;
      seg_q        <= seg_d;
      sof_q        <= sof_d;
      param_q      <= param_d;
      data_byte_q  <= data_byte_d;
      done_q       <= done_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign o_data        = data_q;
  assign o_data_valid  = data_valid_q;
  assign o_hdr_valid   = hdr_valid_q;
  assign o_row_number  = row_q;
  assign o_segment_num = seg_q;
  assign o_sof         = sof_q;
  assign o_param_flag  = param_q;
  assign o_data_byte   = data_byte_q;
  assign o_frame_done  = done_q;
  assign o_frame_ok    = ok_q;
  assign o_crc_err     = err_q;
  assign o_busy        = busy_q;

endmodule
